// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with hold, bubble and flush control.
// Optional perf counters are compiled in with PIPE_STAGE_PERF_EN.
//
// Ports:
//   CLK, NRST          clock; synchronous active-low reset
//   in_valid           upstream stage holds a real instruction
//   in_pc/inst/data    upstream payload
//   in_ctrl            upstream control bits
//   hold               freeze all stage contents
//   bubble             pass payload, kill control and valid
//   flush              kill stage, out_pc <= redirect_pc - REDIRECT_ADJ
//   redirect_pc        corrected next PC
//   out_*              registered stage contents
//   cnt_valid/bubble/flush  saturating perf counters
//                           (constant 0 without PIPE_STAGE_PERF_EN)
// Priority per cycle: reset > flush > hold > bubble > normal.

module pipe_stage_reg #(
  parameter int PC_W         = 13,
  parameter int INST_W       = 32,
  parameter int DATA_W       = 96,
  parameter int CTRL_W       = 21,
  parameter int REDIRECT_ADJ = 2,
  parameter int PERF_W       = 32
) (
  input  logic              CLK,
  input  logic              NRST,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              hold,
  input  logic              bubble,
  input  logic              flush,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [PERF_W-1:0] cnt_valid,
  output logic [PERF_W-1:0] cnt_bubble,
  output logic [PERF_W-1:0] cnt_flush
);

  typedef enum logic [1:0] {
    M_NORM,
    M_BUB,
    M_HOLD,
    M_FLUSH
  } mode_e;

  mode_e mode;

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Collapse overlapping controls into one mode by priority.
  always_comb begin
    mode = M_NORM;
    if (flush)
      mode = M_FLUSH;
    else if (hold)
      mode = M_HOLD;
    else if (bubble)
      mode = M_BUB;
  end

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    unique case (mode)
      M_FLUSH: begin
        // Modular subtract: wraps below zero.
        pc_d    = redirect_pc - PC_W'(REDIRECT_ADJ);
        inst_d  = '0;
        data_d  = in_data;
        ctrl_d  = '0;
        valid_d = 1'b0;
      end
      M_HOLD: begin
      end
      M_BUB: begin
        pc_d    = in_pc;
        inst_d  = in_inst;
        data_d  = in_data;
        ctrl_d  = '0;
        valid_d = 1'b0;
      end
      M_NORM: begin
        pc_d    = in_pc;
        inst_d  = in_inst;
        data_d  = in_data;
        ctrl_d  = in_valid ? in_ctrl : '0;
        valid_d = in_valid;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [PERF_W-1:0] cv_q, cv_d;
  logic [PERF_W-1:0] cb_q, cb_d;
  logic [PERF_W-1:0] cf_q, cf_d;

  // Each counter sticks at all-ones.
  always_comb begin
    cv_d = cv_q;
    cb_d = cb_q;
    cf_d = cf_q;
    unique case (mode)
      M_NORM:
        if (in_valid && cv_q != '1)
          cv_d = cv_q + PERF_W'(1);
      M_BUB:
        if (cb_q != '1)
          cb_d = cb_q + PERF_W'(1);
      M_FLUSH:
        if (cf_q != '1)
          cf_d = cf_q + PERF_W'(1);
      M_HOLD: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!NRST) begin
      cv_q <= '0;
      cb_q <= '0;
      cf_q <= '0;
    end else begin
      cv_q <= cv_d;
      cb_q <= cb_d;
      cf_q <= cf_d;
    end
  end

  assign cnt_valid  = cv_q;
  assign cnt_bubble = cb_q;
  assign cnt_flush  = cf_q;
`else
  assign cnt_valid  = '0;
  assign cnt_bubble = '0;
  assign cnt_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed vector bench for pipe_stage_reg.
// Counter expectations follow PIPE_STAGE_PERF_EN.

module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK;
  logic        NRST;
  logic        in_valid;
  logic [12:0] in_pc;
  logic [31:0] in_inst;
  logic [95:0] in_data;
  logic [20:0] in_ctrl;
  logic        hold, bubble, flush;
  logic [12:0] redirect_pc;

  logic        out_valid;
  logic [12:0] out_pc;
  logic [31:0] out_inst;
  logic [95:0] out_data;
  logic [20:0] out_ctrl;
  logic [31:0] cnt_valid, cnt_bubble, cnt_flush;

  logic        s_valid;
  logic [12:0] s_pc;
  logic [31:0] s_inst;
  logic [95:0] s_data;
  logic [20:0] s_ctrl;
  logic [3:0]  s_cv, s_cb, s_cf;

  pipe_stage_reg dut (
    .CLK(CLK), .NRST(NRST),
    .in_valid(in_valid), .in_pc(in_pc),
    .in_inst(in_inst), .in_data(in_data),
    .in_ctrl(in_ctrl), .hold(hold),
    .bubble(bubble), .flush(flush),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_pc(out_pc),
    .out_inst(out_inst), .out_data(out_data),
    .out_ctrl(out_ctrl),
    .cnt_valid(cnt_valid),
    .cnt_bubble(cnt_bubble),
    .cnt_flush(cnt_flush)
  );

  pipe_stage_reg #(.PERF_W(4)) dut_s (
    .CLK(CLK), .NRST(NRST),
    .in_valid(in_valid), .in_pc(in_pc),
    .in_inst(in_inst), .in_data(in_data),
    .in_ctrl(in_ctrl), .hold(hold),
    .bubble(bubble), .flush(flush),
    .redirect_pc(redirect_pc),
    .out_valid(s_valid), .out_pc(s_pc),
    .out_inst(s_inst), .out_data(s_data),
    .out_ctrl(s_ctrl),
    .cnt_valid(s_cv),
    .cnt_bubble(s_cb),
    .cnt_flush(s_cf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        nrst, vld, hld, bub, fl;
    logic [12:0] pc, rpc;
    logic [31:0] inst;
    logic [95:0] data;
    logic [20:0] ctrl;
    logic        e_vld;
    logic [12:0] e_pc;
    logic [31:0] e_inst;
    logic [95:0] e_data;
    logic [20:0] e_ctrl;
    logic        crst;
    int          dv, db, df;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int m_cv = 0, m_cb = 0, m_cf = 0;
  vec_t tbl[15];

  function automatic vec_t mk(
    logic nrst, logic vld, logic hld,
    logic bub, logic fl,
    logic [12:0] pc, logic [12:0] rpc,
    logic [31:0] inst, logic [95:0] data,
    logic [20:0] ctrl,
    logic e_vld, logic [12:0] e_pc,
    logic [31:0] e_inst, logic [95:0] e_data,
    logic [20:0] e_ctrl,
    logic crst, int dv, int db, int df);
    vec_t v;
    v.nrst = nrst; v.vld = vld; v.hld = hld;
    v.bub = bub; v.fl = fl; v.pc = pc;
    v.rpc = rpc; v.inst = inst; v.data = data;
    v.ctrl = ctrl; v.e_vld = e_vld;
    v.e_pc = e_pc; v.e_inst = e_inst;
    v.e_data = e_data; v.e_ctrl = e_ctrl;
    v.crst = crst; v.dv = dv; v.db = db;
    v.df = df;
    return v;
  endfunction

  task automatic drive(vec_t v);
    @(negedge CLK);
    NRST = v.nrst; in_valid = v.vld;
    hold = v.hld; bubble = v.bub;
    flush = v.fl; in_pc = v.pc;
    redirect_pc = v.rpc; in_inst = v.inst;
    in_data = v.data; in_ctrl = v.ctrl;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  localparam logic [95:0] D2  = 96'hA000_0001_0000_0000_0000_0002;
  localparam logic [95:0] D3  = 96'hB000_0002_0000_0000_0000_0003;
  localparam logic [95:0] D4  = 96'hC000_0003_0000_0000_0000_0004;
  localparam logic [95:0] D5  = 96'hD000_0004_0000_0000_0000_0005;
  localparam logic [95:0] DX  = 96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [95:0] D10 = 96'h1234_5678_9ABC_DEF0_0000_0010;
  localparam logic [95:0] D11 = 96'h0000_0000_0000_0000_0000_0011;
  localparam logic [95:0] D14 = 96'h5555_AAAA_5555_AAAA_5555_0014;

  initial begin
    NRST = 1'b0; in_valid = 1'b0; hold = 1'b0;
    bubble = 1'b0; flush = 1'b0; in_pc = '0;
    in_inst = '0; in_data = '0; in_ctrl = '0;
    redirect_pc = '0;

    // reset with every control raised
    tbl[0]  = mk(0,1,1,1,1, 13'h7, 13'h9, 32'h1, DX, 21'h1,
                 0, 13'h0, 32'h0, 96'h0, 21'h0, 1,0,0,0);
    tbl[1]  = mk(0,1,0,0,0, 13'h3, 13'h0, 32'h2, DX, 21'h3,
                 0, 13'h0, 32'h0, 96'h0, 21'h0, 1,0,0,0);
    // normal
    tbl[2]  = mk(1,1,0,0,0, 13'h010, 13'h0, 32'h00500093, D2,
                 21'h1,
                 1, 13'h010, 32'h00500093, D2, 21'h1,
                 0,1,0,0);
    // bubble
    tbl[3]  = mk(1,1,0,1,0, 13'h020, 13'h0, 32'h11, D3,
                 21'h1FFFFF,
                 0, 13'h020, 32'h11, D3, 21'h0, 0,0,1,0);
    // flush + hold + bubble
    tbl[4]  = mk(1,1,1,1,1, 13'h030, 13'h100, 32'h44, D4,
                 21'h7,
                 0, 13'h0FE, 32'h0, D4, 21'h0, 0,0,0,1);
    tbl[5]  = mk(1,1,0,0,0, 13'h040, 13'h0, 32'h22, D5, 21'h5,
                 1, 13'h040, 32'h22, D5, 21'h5, 0,1,0,0);
    // hold x3 with changing inputs
    tbl[6]  = mk(1,1,1,0,0, 13'h041, 13'h0, 32'h99, DX, 21'h6,
                 1, 13'h040, 32'h22, D5, 21'h5, 0,0,0,0);
    tbl[7]  = mk(1,0,1,0,0, 13'h042, 13'h5, 32'h98, D2, 21'h0,
                 1, 13'h040, 32'h22, D5, 21'h5, 0,0,0,0);
    tbl[8]  = mk(1,1,1,0,0, 13'h1FFF, 13'h0, 32'h97, D3,
                 21'h1FFFFF,
                 1, 13'h040, 32'h22, D5, 21'h5, 0,0,0,0);
    // hold + bubble acts as hold
    tbl[9]  = mk(1,1,1,1,0, 13'h043, 13'h0, 32'h96, D4, 21'h2,
                 1, 13'h040, 32'h22, D5, 21'h5, 0,0,0,0);
    // normal, invalid input kills ctrl
    tbl[10] = mk(1,0,0,0,0, 13'h050, 13'h0, 32'h55, D10, 21'h7,
                 0, 13'h050, 32'h55, D10, 21'h0, 0,0,0,0);
    // flush wrap below zero
    tbl[11] = mk(1,1,0,0,1, 13'h060, 13'h0, 32'h66, D11, 21'h3,
                 0, 13'h1FFE, 32'h0, D11, 21'h0, 0,0,0,1);
    // reset mid-hold
    tbl[12] = mk(0,1,1,0,0, 13'h070, 13'h0, 32'h77, DX, 21'h3,
                 0, 13'h0, 32'h0, 96'h0, 21'h0, 1,0,0,0);
    tbl[13] = mk(1,1,1,0,0, 13'h071, 13'h0, 32'h78, DX, 21'h3,
                 0, 13'h0, 32'h0, 96'h0, 21'h0, 0,0,0,0);
    tbl[14] = mk(1,1,0,0,0, 13'h060, 13'h0, 32'h33, D14, 21'h9,
                 1, 13'h060, 32'h33, D14, 21'h9, 0,1,0,0);

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i]);
      if (tbl[i].crst) begin
        m_cv = 0; m_cb = 0; m_cf = 0;
      end else begin
        m_cv += tbl[i].dv;
        m_cb += tbl[i].db;
        m_cf += tbl[i].df;
      end
      chk($sformatf("v%0d.valid", i),
          128'(out_valid), 128'(tbl[i].e_vld));
      chk($sformatf("v%0d.pc", i),
          128'(out_pc), 128'(tbl[i].e_pc));
      chk($sformatf("v%0d.inst", i),
          128'(out_inst), 128'(tbl[i].e_inst));
      chk($sformatf("v%0d.data", i),
          128'(out_data), 128'(tbl[i].e_data));
      chk($sformatf("v%0d.ctrl", i),
          128'(out_ctrl), 128'(tbl[i].e_ctrl));
      chk($sformatf("v%0d.cnt_valid", i),
          128'(cnt_valid), PERF ? 128'(m_cv) : 128'(0));
      chk($sformatf("v%0d.cnt_bubble", i),
          128'(cnt_bubble), PERF ? 128'(m_cb) : 128'(0));
      chk($sformatf("v%0d.cnt_flush", i),
          128'(cnt_flush), PERF ? 128'(m_cf) : 128'(0));
    end

    // saturation: 20 valid cycles into a 4-bit counter
    drive(mk(0,0,0,0,0, 13'h0, 13'h0, 32'h0, 96'h0, 21'h0,
             0, 13'h0, 32'h0, 96'h0, 21'h0, 1,0,0,0));
    chk("sat.reset", 128'(s_cv), 128'(0));
    for (int k = 0; k < 20; k++) begin
      drive(mk(1,1,0,0,0, 13'(k), 13'h0, 32'(k), 96'(k),
               21'h1,
               1, 13'(k), 32'(k), 96'(k), 21'h1, 0,1,0,0));
      if (k == 14)
        chk("sat.cnt15", 128'(s_cv),
            PERF ? 128'(15) : 128'(0));
    end
    chk("sat.cnt_valid", 128'(s_cv),
        PERF ? 128'(4'hF) : 128'(0));
    chk("sat.cnt_bubble", 128'(s_cb), 128'(0));
    chk("sat.wide_cnt", 128'(cnt_valid),
        PERF ? 128'(20) : 128'(0));
    chk("sat.pc", 128'(s_pc), 128'(13'd19));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PC_W, default 13, program-counter width.
REQ-002 SHALL have parameter INST_W, default 32, instruction width.
REQ-003 SHALL have parameter DATA_W, default 96, packed operand payload width (source1, source2, imm).
REQ-004 SHALL have parameter CTRL_W, default 21, packed control-signal width.
REQ-005 SHALL have parameter REDIRECT_ADJ, default 2, PC offset subtracted on flush.
REQ-006 SHALL have parameter PERF_W, default 32, performance-counter width.
REQ-007 SHALL have ports, one per line:
 CLK  in  1  clock, all state updates on rising edge
 NRST  in  1  reset, synchronous, active-low
 in_valid  in  1  upstream stage holds a real instruction
 in_pc  in  PC_W  upstream PC
 in_inst  in  INST_W  upstream instruction
 in_data  in  DATA_W  upstream operand payload
 in_ctrl  in  CTRL_W  upstream control bits
 hold  in  1  freeze all stage contents
 bubble  in  1  pass payload, kill control (load-use stall)
 flush  in  1  branch mispredict, kill stage
 redirect_pc  in  PC_W  corrected next PC
 out_valid  out  1  stage holds a real instruction
 out_pc  out  PC_W  registered PC
 out_inst  out  INST_W  registered instruction
 out_data  out  DATA_W  registered payload
 out_ctrl  out  CTRL_W  registered control bits
 cnt_valid, cnt_bubble, cnt_flush  out  PERF_W each  performance counters (REQ-022)

Function
REQ-008 SHALL register all outputs; no combinational path from inputs to outputs.
REQ-009 SHALL resolve each cycle with priority: reset > flush > hold > bubble > normal.
REQ-010 Normal (no control asserted): out_pc<=in_pc, out_inst<=in_inst, out_data<=in_data, out_valid<=in_valid, out_ctrl<=in_valid ? in_ctrl : 0.
REQ-011 Bubble: out_pc, out_inst, out_data load from inputs; out_ctrl<=0; out_valid<=0.
REQ-012 Flush: out_inst<=0; out_ctrl<=0; out_valid<=0; out_pc<=redirect_pc - REDIRECT_ADJ, modulo 2^PC_W; out_data loads in_data.
REQ-013 Hold without flush: every output register retains its value, including out_valid and out_ctrl.
REQ-014 Flush with hold SHALL behave as flush alone.
REQ-015 Flush with bubble SHALL behave as flush alone.
REQ-016 Hold with bubble SHALL behave as hold alone.
REQ-017 Latency SHALL be exactly one cycle from input to output in normal and bubble modes.
REQ-018 Flush at redirect_pc=0 with default parameters SHALL yield out_pc=13'h1FFE (wrap, no saturation).

Reset
REQ-019 NRST low at a rising edge SHALL zero out_pc, out_inst, out_data, out_ctrl and out_valid, regardless of hold, bubble or flush.
REQ-020 NRST low SHALL zero all performance counters when they are compiled in.
REQ-021 Reset asserted mid-hold SHALL clear state, and the first cycle after release SHALL follow REQ-009.

Configuration
REQ-022 With macro PIPE_STAGE_PERF_EN defined, the counters SHALL be updated per cycle, applying REQ-009 priority:
 - cnt_valid +1 on each normal-mode cycle with in_valid=1.
 - cnt_bubble +1 on each bubble-mode cycle.
 - cnt_flush +1 on each flush-mode cycle.
 - Hold cycles SHALL increment no counter.
 - Each counter SHALL saturate at all-ones.
REQ-023 Without PIPE_STAGE_PERF_EN, counter ports SHALL exist and be tied to constant 0, with no counter flops.

Verification
REQ-024 Reset then normal: NRST=0 for 2 cycles, then in_valid=1, in_pc=0x010, in_inst=0x00500093, in_ctrl=0x1 -> next cycle out_pc=0x010, out_inst=0x00500093, out_ctrl=0x1, out_valid=1.
REQ-025 Bubble: bubble=1, in_pc=0x020, in_ctrl=0x1FFFFF -> out_pc=0x020, out_ctrl=0, out_valid=0, cnt_bubble +1.
REQ-026 Flush with hold: flush=1, hold=1, bubble=1, redirect_pc=0x100 -> out_pc=0x0FE, out_inst=0, out_ctrl=0, out_valid=0, only cnt_flush +1.
REQ-027 Hold: load in_pc=0x040, then hold=1 for 3 cycles while inputs change -> outputs stay at pc=0x040 and counters unchanged.
REQ-028 Wrap and saturation: flush at redirect_pc=0 -> out_pc=0x1FFE; with PERF_W=4, 20 valid cycles -> cnt_valid=0xF.
REQ-029 Build without PIPE_STAGE_PERF_EN: repeat REQ-025 -> all counters read 0.
